// File: rtl/reg_bank_pkg.sv
// Shared definitions for the FunSel register bank: operation encodings and parameter limits.
// Latency: none (package only).
// Backpressure: none (package only).
package reg_bank_pkg;

   // FunSel operation encodings
   localparam logic [2:0] FS_DEC    = 3'b000;  // Q - 1
   localparam logic [2:0] FS_INC    = 3'b001;  // Q + 1
   localparam logic [2:0] FS_LOAD   = 3'b010;  // Q <= I
   localparam logic [2:0] FS_CLR    = 3'b011;  // Q <= 0
   localparam logic [2:0] FS_LOAD8  = 3'b100;  // Q <= zero-extended I[7:0]
   localparam logic [2:0] FS_LOAD16 = 3'b101;  // Q <= zero-extended I[15:0]
   localparam logic [2:0] FS_SHL8   = 3'b110;  // Q <= {Q[WIDTH-9:0], I[7:0]}
   localparam logic [2:0] FS_SEXT16 = 3'b111;  // Q <= sign-extended I[15:0]

   // Supported parameter ranges; the byte/halfword ops need WIDTH >= 16
   localparam int WIDTH_MIN    = 16;
   localparam int WIDTH_MAX    = 64;
   localparam int NUM_REGS_MIN = 2;
   localparam int NUM_REGS_MAX = 16;

   // True when the op is one of the counting ops that can cross the wrap boundary
   function automatic logic is_count_op(input logic [2:0] fs);
      return (fs == FS_DEC) || (fs == FS_INC);
   endfunction

endpackage

// File: rtl/reg_bank_funsel_reg_cell.sv
// One WIDTH-bit register applying the FunSel op when E is high, with a boundary-crossing strobe.
// Latency: Q and Wrap update one cycle after the enabling edge.
// Backpressure: none; a write is always accepted on the edge where E is high.
// Option: REG_BANK_SATURATE_EN makes dec at 0 / inc at all-ones hold instead of wrapping.
module reg_cell #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             E,
   input  logic [2:0]       FunSel,
   input  logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] Q,
   output logic             Wrap
);
   import reg_bank_pkg::*;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] q_next;
   logic             at_boundary;

   // Next-state value for the selected op and detection of a dec-at-0 / inc-at-all-ones event
   always_comb begin
      q_next      = Q;
      at_boundary = 1'b0;
      case (FunSel)
         FS_DEC: begin
            at_boundary = (Q == '0);
`ifdef REG_BANK_SATURATE_EN
            q_next = at_boundary ? Q : (Q - WIDTH'(1));
`else
            q_next = Q - WIDTH'(1);
`endif
         end
         FS_INC: begin
            at_boundary = (Q == ALL_ONES);
`ifdef REG_BANK_SATURATE_EN
            q_next = at_boundary ? Q : (Q + WIDTH'(1));
`else
            q_next = Q + WIDTH'(1);
`endif
         end
         FS_LOAD:   q_next = I;
         FS_CLR:    q_next = '0;
         FS_LOAD8:  q_next = {{(WIDTH-8){1'b0}}, I[7:0]};
         FS_LOAD16: q_next = WIDTH'(I[15:0]);
         FS_SHL8:   q_next = {Q[WIDTH-9:0], I[7:0]};
         FS_SEXT16: q_next = WIDTH'($signed(I[15:0]));
         default:   q_next = Q;
      endcase
      // only the counting ops can raise the strobe
      if (!is_count_op(FunSel)) begin
         at_boundary = 1'b0;
      end
   end

   // Register update and one-cycle Wrap strobe; reset clears both immediately
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Q    <= '0;
         Wrap <= 1'b0;
      end else begin
         Wrap <= E & at_boundary;
         if (E) begin
            Q <= q_next;
         end
      end
   end

endmodule

// File: rtl/reg_bank_funsel.sv
// Bank of NUM_REGS FunSel registers with a broadcast write port, two read ports and per-register flags.
// Latency: writes visible on OutA/OutB/Zero one cycle after the edge; reads are combinational.
// Backpressure: none; every enabled register takes the op on each rising edge.
// Option: REG_BANK_SATURATE_EN (handled inside reg_cell) saturates inc/dec instead of wrapping.
module reg_bank_funsel #(
   parameter  int WIDTH    = 32,
   parameter  int NUM_REGS = 4,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [NUM_REGS-1:0] RegEn,
   input  logic [2:0]          FunSel,
   input  logic [WIDTH-1:0]    I,
   input  logic [SEL_W-1:0]    OutASel,
   input  logic [SEL_W-1:0]    OutBSel,
   output logic [WIDTH-1:0]    OutA,
   output logic [WIDTH-1:0]    OutB,
   output logic [NUM_REGS-1:0] Wrap,
   output logic [NUM_REGS-1:0] Zero
);
   import reg_bank_pkg::*;

   logic [WIDTH-1:0] q_arr [NUM_REGS];

   // One cell per register; op and data are broadcast, each cell gated by its own enable
   for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
      reg_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .Clock  (Clock),
         .Reset  (Reset),
         .E      (RegEn[n]),
         .FunSel (FunSel),
         .I      (I),
         .Q      (q_arr[n]),
         .Wrap   (Wrap[n])
      );

      assign Zero[n] = (q_arr[n] == '0);
   end

   // Read port A: selects beyond the last register read as zero
   always_comb begin
      OutA = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (OutASel == SEL_W'(n)) begin
            OutA = q_arr[n];
         end
      end
   end

   // Read port B: same mux as port A, independent select
   always_comb begin
      OutB = '0;
      for (int n = 0; n < NUM_REGS; n++) begin
         if (OutBSel == SEL_W'(n)) begin
            OutB = q_arr[n];
         end
      end
   end

endmodule

// File: tb/tb_reg_bank_funsel.sv
// Self-checking bench for reg_bank_funsel: three configurations (32x4, 32x3, 16x16) sharing clock/reset.
// Expected values come from a bench-side reference model and flow through a FIFO scoreboard.
// Build with REG_BANK_SATURATE_EN to exercise the saturating variant.
module tb_reg_bank_funsel;

`ifdef REG_BANK_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #10 Clock = ~Clock;

   // 32-bit x 4
   logic [3:0]  d4_en = '0;
   logic [2:0]  d4_fs = '0;
   logic [31:0] d4_i = '0;
   logic [1:0]  d4_sela = '0, d4_selb = '0;
   logic [31:0] d4_outa, d4_outb;
   logic [3:0]  d4_wrap, d4_zero;

   // 32-bit x 3 (out-of-range select)
   logic [2:0]  d3_en = '0;
   logic [2:0]  d3_fs = '0;
   logic [31:0] d3_i = '0;
   logic [1:0]  d3_sela = '0, d3_selb = '0;
   logic [31:0] d3_outa, d3_outb;
   logic [2:0]  d3_wrap, d3_zero;

   // 16-bit x 16
   logic [15:0] d16_en = '0;
   logic [2:0]  d16_fs = '0;
   logic [15:0] d16_i = '0;
   logic [3:0]  d16_sela = '0, d16_selb = '0;
   logic [15:0] d16_outa, d16_outb;
   logic [15:0] d16_wrap, d16_zero;

   reg_bank_funsel #(.WIDTH(32), .NUM_REGS(4)) u_d4 (
      .Clock(Clock), .Reset(Reset), .RegEn(d4_en), .FunSel(d4_fs), .I(d4_i),
      .OutASel(d4_sela), .OutBSel(d4_selb), .OutA(d4_outa), .OutB(d4_outb),
      .Wrap(d4_wrap), .Zero(d4_zero));

   reg_bank_funsel #(.WIDTH(32), .NUM_REGS(3)) u_d3 (
      .Clock(Clock), .Reset(Reset), .RegEn(d3_en), .FunSel(d3_fs), .I(d3_i),
      .OutASel(d3_sela), .OutBSel(d3_selb), .OutA(d3_outa), .OutB(d3_outb),
      .Wrap(d3_wrap), .Zero(d3_zero));

   reg_bank_funsel #(.WIDTH(16), .NUM_REGS(16)) u_d16 (
      .Clock(Clock), .Reset(Reset), .RegEn(d16_en), .FunSel(d16_fs), .I(d16_i),
      .OutASel(d16_sela), .OutBSel(d16_selb), .OutA(d16_outa), .OutB(d16_outb),
      .Wrap(d16_wrap), .Zero(d16_zero));

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   // reference model state for the 32x4 instance
   logic [63:0] m4[4];
   logic [3:0]  m4_wrap;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [63:0] got);
      logic [63:0] e;
      if (exp_q.size() == 0) e = ~got;
      else e = exp_q.pop_front();
      check_val(tag, got, e);
   endtask

   function automatic logic [63:0] width_mask(input int w);
      return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic logic [63:0] model_next(input logic [63:0] q, input logic [2:0] fs,
                                              input logic [63:0] d, input int w);
      logic [63:0] mask;
      logic [63:0] r;
      mask = width_mask(w);
      case (fs)
         3'd0: r = (q == 0) ? (SAT ? 64'd0 : mask) : q - 64'd1;
         3'd1: r = (q == mask) ? (SAT ? mask : 64'd0) : q + 64'd1;
         3'd2: r = d & mask;
         3'd3: r = 64'd0;
         3'd4: r = d & 64'hFF;
         3'd5: r = d & 64'hFFFF;
         3'd6: r = ((q << 8) | (d & 64'hFF)) & mask;
         default: r = d[15] ? ((mask & ~64'hFFFF) | (d & 64'hFFFF)) : (d & 64'hFFFF);
      endcase
      return r;
   endfunction

   function automatic bit model_wrap(input logic [63:0] q, input logic [2:0] fs, input int w);
      return ((fs == 3'd0) && (q == 0)) || ((fs == 3'd1) && (q == width_mask(w)));
   endfunction

   task automatic push4();
      logic [3:0] z;
      for (int n = 0; n < 4; n++) z[n] = (m4[n] == 0);
      exp_q.push_back(64'(m4_wrap));
      exp_q.push_back(64'(z));
      for (int n = 0; n < 4; n++) begin
         exp_q.push_back(m4[n]);
         exp_q.push_back(m4[3-n]);
      end
   endtask

   task automatic compare4(input string ctx);
      check_pop({ctx, "_wrap"}, 64'(d4_wrap));
      check_pop({ctx, "_zero"}, 64'(d4_zero));
      for (int n = 0; n < 4; n++) begin
         d4_sela = 2'(n);
         d4_selb = 2'(3 - n);
         #1;
         check_pop($sformatf("%s_outa_r%0d", ctx, n), 64'(d4_outa));
         check_pop($sformatf("%s_outb_r%0d", ctx, 3 - n), 64'(d4_outb));
      end
   endtask

   // drive one op, predict, let the edge happen, then compare
   task automatic apply4(input string ctx, input logic [3:0] en, input logic [2:0] fs,
                         input logic [31:0] d);
      d4_en = en;
      d4_fs = fs;
      d4_i  = d;
      for (int n = 0; n < 4; n++) begin
         if (en[n]) begin
            m4_wrap[n] = model_wrap(m4[n], fs, 32);
            m4[n]      = model_next(m4[n], fs, 64'(d), 32);
         end else begin
            m4_wrap[n] = 1'b0;
         end
      end
      push4();
      @(posedge Clock);
      #1;
      d4_en = '0;
      compare4(ctx);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [63:0] r5;
      for (int n = 0; n < 4; n++) m4[n] = '0;
      m4_wrap = '0;

      // reset state of all three instances while Reset is held
      @(posedge Clock);
      @(posedge Clock);
      #3;
      push4();
      compare4("rst");
      exp_q.push_back(64'h7); exp_q.push_back(64'h0);
      check_pop("rst_d3_zero", 64'(d3_zero));
      check_pop("rst_d3_wrap", 64'(d3_wrap));
      exp_q.push_back(64'hFFFF); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
      check_pop("rst_d16_zero", 64'(d16_zero));
      check_pop("rst_d16_wrap", 64'(d16_wrap));
      check_pop("rst_d16_outa", 64'(d16_outa));
      Reset = 1'b0;

      // decrement from zero, then the strobe must drop on the following edge
      apply4("dec0", 4'b0001, 3'b000, 32'h0);
      apply4("dec0_idle", 4'b0000, 3'b000, 32'h0);

      // load then shift a byte in
      apply4("load", 4'b0001, 3'b010, 32'h1234_ABCD);
      apply4("shl8", 4'b0001, 3'b110, 32'h0000_00EF);

      // sign/zero extension variants on R1
      apply4("sext16", 4'b0010, 3'b111, 32'h0000_8001);
      apply4("load16", 4'b0010, 3'b101, 32'h0000_8001);
      apply4("load8",  4'b0010, 3'b100, 32'h0000_8001);

      // increment past all ones on R2
      apply4("load_ff", 4'b0100, 3'b010, 32'hFFFF_FFFF);
      apply4("inc_ff",  4'b0100, 3'b001, 32'h0);

      // distinct values, then multi-hot increment
      apply4("ld_r0", 4'b0001, 3'b010, 32'd10);
      apply4("ld_r1", 4'b0010, 3'b010, 32'd20);
      apply4("ld_r2", 4'b0100, 3'b010, 32'd30);
      apply4("ld_r3", 4'b1000, 3'b010, 32'd40);
      apply4("inc_0101", 4'b0101, 3'b001, 32'h0);

      // pending write to R2 must not be visible before its edge
      d4_selb = 2'd2;
      d4_en = 4'b0100; d4_fs = 3'b010; d4_i = 32'h5555_0000;
      #1;
      exp_q.push_back(m4[2]);
      check_pop("no_bypass_outb", 64'(d4_outb));
      apply4("post_edge", 4'b0100, 3'b010, 32'h5555_0000);

      // leave a Wrap pulse pending, then reset mid-cycle with a write queued
      apply4("clr_r3", 4'b1000, 3'b011, 32'h0);
      apply4("dec_r3", 4'b1000, 3'b000, 32'h0);
      d4_en = 4'hF; d4_fs = 3'b010; d4_i = 32'hDEAD_BEEF;
      #2;
      Reset = 1'b1;
      #1;
      for (int n = 0; n < 4; n++) m4[n] = '0;
      m4_wrap = '0;
      push4();
      compare4("rst_mid");
      @(posedge Clock);
      #1;
      push4();
      compare4("rst_hold");
      #3;
      Reset = 1'b0;
      apply4("first_after_rst", 4'hF, 3'b010, 32'hDEAD_BEEF);

      // 3-register bank: select 3 is out of range
      d3_en = 3'b111; d3_fs = 3'b010; d3_i = 32'hCAFE_0003;
      exp_q.push_back(64'h0); exp_q.push_back(64'h0);
      exp_q.push_back(64'hCAFE_0003); exp_q.push_back(64'h0);
      @(posedge Clock);
      #1;
      d3_en = '0;
      d3_sela = 2'd3; d3_selb = 2'd3;
      #1;
      check_pop("d3_outa_sel3", 64'(d3_outa));
      check_pop("d3_outb_sel3", 64'(d3_outb));
      d3_sela = 2'd2;
      #1;
      check_pop("d3_outa_sel2", 64'(d3_outa));
      check_pop("d3_zero", 64'(d3_zero));

      // 16x16 bank: sign-extend at full width, then wrap on 0xFFFF + 1
      d16_en = 16'h8000; d16_fs = 3'b111; d16_i = 16'h8000;
      exp_q.push_back(model_next(64'h0, 3'b111, 64'h8000, 16));
      @(posedge Clock);
      #1;
      d16_en = '0;
      d16_sela = 4'd15;
      #1;
      check_pop("d16_sext_r15", 64'(d16_outa));

      d16_en = 16'h0020; d16_fs = 3'b010; d16_i = 16'hFFFF;
      r5 = model_next(64'h0, 3'b010, 64'hFFFF, 16);
      @(posedge Clock);
      #1;
      d16_en = 16'h0020; d16_fs = 3'b001; d16_i = 16'h0;
      exp_q.push_back(model_wrap(r5, 3'b001, 16) ? 64'h0020 : 64'h0);
      r5 = model_next(r5, 3'b001, 64'h0, 16);
      exp_q.push_back(r5);
      exp_q.push_back((r5 == 0) ? 64'h0020 : 64'h0);
      @(posedge Clock);
      #1;
      d16_en = '0;
      check_pop("d16_wrap", 64'(d16_wrap));
      d16_selb = 4'd5;
      #1;
      check_pop("d16_inc_r5", 64'(d16_outb));
      check_pop("d16_zero_r5", 64'(d16_zero & 16'h0020));

      check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
